sprite_palette_arbiter: RTL

- Shares one synchronous sprite ROM, which outputs 4-bit palette indices, between up to NUM_LAYERS overlapping sprite layers (bird, long pipe, brick, background objects) for each VGA pixel.
- For each pixel request it probes the hit layers in priority order and skips texels whose index is the transparent key.
- It returns the first opaque palette index, plus the winning layer, to the colour-palette stage that produces the 8-bit R/G/B values.
- Sits between the per-layer sprite address generators and the palette lookup.

---
 rtl/sprite_palette_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/sprite_palette_arbiter.sv
// sprite_palette_arbiter: shares one sprite ROM between prioritised layers and
// returns the first opaque palette index (or the background index) per pixel.
module sprite_palette_arbiter #(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W = 12,
  parameter int IDX_W = 4,
  parameter logic [IDX_W-1:0] TRANSPARENT_IDX = IDX_W'('hB),
  parameter logic [IDX_W-1:0] BG_IDX = '0,
  localparam int LW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_LAYERS-1:0]        layer_hit,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  output logic                         rom_rd,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [IDX_W-1:0]             rom_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_idx,
  output logic [LW-1:0]                out_layer,
  output logic                         out_bg
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]                   state;
  logic [NUM_LAYERS-1:0]        pending;
  logic [NUM_LAYERS-1:0]        pend_left;
  logic [NUM_LAYERS*ADDR_W-1:0] addr_q;
  logic [LW-1:0]                cur;

  // cur is the lowest-numbered pending layer; pending holds still between ISSUE and CHECK
  always_comb begin
    cur = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (pending[i]) cur = LW'(i);
  end

  assign pend_left = pending & ~(NUM_LAYERS'(1) << cur);
  assign in_ready  = Reset_n && state == IDLE;
  assign rom_rd    = state == ISSUE;
  assign rom_addr  = state == ISSUE ? addr_q[cur*ADDR_W +: ADDR_W] : '0;
  assign out_valid = state == OUT;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      pending   <= '0;
      addr_q    <= '0;
      out_idx   <= '0;
      out_layer <= '0;
      out_bg    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          pending <= layer_hit;
          addr_q  <= layer_addr;
          if (layer_hit == '0) begin
            out_idx   <= BG_IDX;
            out_layer <= '0;
            out_bg    <= 1'b1;
            state     <= OUT;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: state <= CHECK;
        CHECK: if (rom_data != TRANSPARENT_IDX) begin
          out_idx   <= rom_data;
          out_layer <= cur;
          out_bg    <= 1'b0;
          state     <= OUT;
        end else begin
          pending <= pend_left;
          if (pend_left != '0) begin
            state <= ISSUE;
          end else begin
            out_idx   <= BG_IDX;
            out_layer <= '0;
            out_bg    <= 1'b1;
            state     <= OUT;
          end
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule
